// File: rtl/flash_op_sequencer.sv
// Flash write/erase sequencer: takes unlocked commands from the register file,
// streams 32-bit words out of the 16-bit staging RAM into the user flash and
// tracks the flash controller busy/fail handshake.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | waiting for an unlocked write or erase command
//   ACCEPT     | ack pulse, clear error, check range and command validity
//   ER_REQ     | wait for flash idle, then issue one-cycle erase strobe
//   ER_WAIT_HI | wait for flash busy to rise
//   ER_WAIT_LO | wait for flash busy to fall, then sample fail
//   RD_LO      | present staging address of low half-word
//   RD_HI      | capture low half, present address of high half-word
//   WR_REQ     | write strobe held until the flash stops stalling
//   WR_WAIT_HI | wait for flash busy to rise
//   WR_WAIT_LO | wait for flash busy to fall, then sample fail
//   NEXT       | advance word index or finish
//   FAIL       | set sticky error, return to IDLE
module flash_op_sequencer #(
  parameter logic [17:0] FLASH_WORDS    = 18'd65536,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [17:0] FlashOpAddr,
  input  logic [5:0]  FlashOpLen,
  input  logic        FlashOpUnlock,
  input  logic        FlashOpWr,
  input  logic        FlashOpEr,
  output logic        FlashCmdAck,
  output logic        FlashBusy,
  output logic        FlashError,
  output logic [6:0]  BufRdAddress,
  input  logic [15:0] BufRdData,
  output logic [17:0] FlashDataAddr,
  output logic [31:0] FlashDataWrData,
  output logic        FlashDataWrite,
  input  logic        FlashDataWaitReq,
  output logic [17:0] FlashEraseAddr,
  output logic        FlashErase,
  input  logic        FlashCtlBusy,
  input  logic        FlashCtlFail
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACCEPT, S_ER_REQ, S_ER_WAIT_HI, S_ER_WAIT_LO, S_RD_LO,
    S_RD_HI, S_WR_REQ, S_WR_WAIT_HI, S_WR_WAIT_LO, S_NEXT, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic        cmd_er_q, cmd_er_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;
  logic [23:0] tmo_q, tmo_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [6:0]  rd_addr_q, rd_addr_d;
  logic [17:0] data_addr_q, data_addr_d;
  logic        wr_q, wr_d;
  logic        erase_q, erase_d;

  logic [18:0] wr_end;
  logic        in_wait;

  assign wr_end  = {1'b0, addr_q} + {13'b0, len_q};
  assign in_wait = (state_q == S_ER_REQ)     || (state_q == S_ER_WAIT_HI) ||
                   (state_q == S_ER_WAIT_LO) || (state_q == S_WR_REQ)     ||
                   (state_q == S_WR_WAIT_HI) || (state_q == S_WR_WAIT_LO);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_er_d    = cmd_er_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    rd_addr_d   = rd_addr_q;
    data_addr_d = data_addr_q;
    busy_d      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (FlashOpUnlock && (FlashOpWr || FlashOpEr)) begin
          state_d  = S_ACCEPT;
          addr_d   = FlashOpAddr;
          len_d    = FlashOpLen;
          cmd_wr_d = FlashOpWr;
          cmd_er_d = FlashOpEr;
        end
      end
      S_ACCEPT: begin
        idx_d = '0;
        if (cmd_wr_q && cmd_er_q)                  state_d = S_FAIL;
        else if (cmd_wr_q) begin
          if (len_q == 6'd0)                       state_d = S_IDLE;
          else if (wr_end > {1'b0, FLASH_WORDS})   state_d = S_FAIL;
          else                                     state_d = S_RD_LO;
        end else if (addr_q >= FLASH_WORDS)        state_d = S_FAIL;
        else                                       state_d = S_ER_REQ;
      end
      S_ER_REQ:     if (!FlashCtlBusy) state_d = S_ER_WAIT_HI;
      S_ER_WAIT_HI: if (FlashCtlBusy)  state_d = S_ER_WAIT_LO;
      S_ER_WAIT_LO: if (!FlashCtlBusy) state_d = FlashCtlFail ? S_FAIL : S_IDLE;
      S_RD_LO:      state_d = S_RD_HI;
      S_RD_HI: begin
        lo_d    = BufRdData;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        hi_d = BufRdData;
        if (!FlashDataWaitReq) state_d = S_WR_WAIT_HI;
      end
      S_WR_WAIT_HI: if (FlashCtlBusy)  state_d = S_WR_WAIT_LO;
      S_WR_WAIT_LO: if (!FlashCtlBusy) state_d = FlashCtlFail ? S_FAIL : S_NEXT;
      S_NEXT: begin
        if (idx_q == len_q - 6'd1) state_d = S_IDLE;
        else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_RD_LO;
        end
      end
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A stuck handshake aborts; strobes fall because they decode state_d.
    if (in_wait && (tmo_q >= TIMEOUT_CYCLES - 24'd1)) state_d = S_FAIL;

    if (state_d != state_q) tmo_d = '0;
    else if (in_wait)       tmo_d = tmo_q + 24'd1;

    if (state_d == S_ACCEPT)    err_d = 1'b0;
    else if (state_d == S_FAIL) err_d = 1'b1;

    if (state_d == S_RD_LO) rd_addr_d = {idx_d, 1'b0};
    if (state_d == S_RD_HI) rd_addr_d = {idx_q, 1'b1};
    if ((state_q == S_RD_HI) && (state_d == S_WR_REQ))
      data_addr_d = addr_q + {12'b0, idx_q};

    ack_d   = (state_d == S_ACCEPT);
    wr_d    = (state_d == S_WR_REQ);
    erase_d = (state_q == S_ER_REQ) && (state_d == S_ER_WAIT_HI);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_er_q    <= 1'b0;
      idx_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      tmo_q       <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_addr_q   <= '0;
      data_addr_q <= '0;
      wr_q        <= 1'b0;
      erase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_er_q    <= cmd_er_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      tmo_q       <= tmo_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      rd_addr_q   <= rd_addr_d;
      data_addr_q <= data_addr_d;
      wr_q        <= wr_d;
      erase_q     <= erase_d;
    end
  end

  assign FlashCmdAck    = ack_q;
  assign FlashBusy      = busy_q;
  assign FlashError     = err_q;
  assign BufRdAddress   = rd_addr_q;
  assign FlashDataAddr  = data_addr_q;
  assign FlashDataWrite = wr_q;
  assign FlashEraseAddr = addr_q;
  assign FlashErase     = erase_q;
  // The high half arrives from the RAM during WR_REQ itself; its address is
  // held there, so the RAM output stays stable for the whole stall.
  assign FlashDataWrData = (state_q == S_WR_REQ) ? {BufRdData, lo_q} : {hi_q, lo_q};

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer with staging RAM and flash models.
module tb_flash_op_sequencer;

  typedef struct packed {
    logic        er;
    logic [17:0] addr;
    logic [31:0] data;
    logic        stable;
  } ev_t;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [17:0] FlashOpAddr = '0;
  logic [5:0]  FlashOpLen = '0;
  logic        FlashOpUnlock = 1'b0, FlashOpWr = 1'b0, FlashOpEr = 1'b0;
  logic        FlashCmdAck, FlashBusy, FlashError;
  logic [6:0]  BufRdAddress;
  logic [15:0] BufRdData = '0;
  logic [17:0] FlashDataAddr, FlashEraseAddr;
  logic [31:0] FlashDataWrData;
  logic        FlashDataWrite, FlashDataWaitReq, FlashErase;
  logic        FlashCtlBusy, FlashCtlFail = 1'b0;

  logic [15:0] ram [0:127];
  int  cfg_busy = 2, cfg_stall = 0;
  bit  stuck = 1'b0, force_stall = 1'b0;
  int  busy_cnt = 0, wr_age = 0;
  int  wr_cycles = 0, er_cycles = 0;
  bit  in_wr = 1'b0, unstable = 1'b0;
  logic [49:0] hold = '0;
  ev_t obs[$];
  ev_t exp_q[$];
  int  rd_ptr = 0;
  int  checks = 0, failures = 0;

  always #5 clk = ~clk;

  flash_op_sequencer #(.FLASH_WORDS(18'd65536), .TIMEOUT_CYCLES(24'd100)) dut (
    .Clock(clk), .Reset(Reset),
    .FlashOpAddr(FlashOpAddr), .FlashOpLen(FlashOpLen), .FlashOpUnlock(FlashOpUnlock),
    .FlashOpWr(FlashOpWr), .FlashOpEr(FlashOpEr),
    .FlashCmdAck(FlashCmdAck), .FlashBusy(FlashBusy), .FlashError(FlashError),
    .BufRdAddress(BufRdAddress), .BufRdData(BufRdData),
    .FlashDataAddr(FlashDataAddr), .FlashDataWrData(FlashDataWrData),
    .FlashDataWrite(FlashDataWrite), .FlashDataWaitReq(FlashDataWaitReq),
    .FlashEraseAddr(FlashEraseAddr), .FlashErase(FlashErase),
    .FlashCtlBusy(FlashCtlBusy), .FlashCtlFail(FlashCtlFail)
  );

  // Staging RAM: registered read, one cycle latency.
  always @(posedge clk) BufRdData <= ram[BufRdAddress];

  assign FlashCtlBusy     = (busy_cnt != 0);
  assign FlashDataWaitReq = force_stall || (FlashDataWrite && (wr_age < cfg_stall));

  // Flash model: records accepted writes/erases, checks write hold stability.
  always @(posedge clk) begin
    ev_t ev;
    if (FlashDataWrite) wr_cycles = wr_cycles + 1;
    if (FlashErase)     er_cycles = er_cycles + 1;
    if (FlashDataWrite) begin
      if (in_wr && ({FlashDataAddr, FlashDataWrData} !== hold)) unstable = 1'b1;
      hold = {FlashDataAddr, FlashDataWrData};
      in_wr = 1'b1;
    end else begin
      in_wr = 1'b0;
      unstable = 1'b0;
    end
    if ((FlashDataWrite && !FlashDataWaitReq) || FlashErase) begin
      ev.er     = FlashErase;
      ev.addr   = FlashErase ? FlashEraseAddr : FlashDataAddr;
      ev.data   = FlashErase ? 32'h0 : FlashDataWrData;
      ev.stable = !unstable;
      obs.push_back(ev);
      in_wr = 1'b0;
      unstable = 1'b0;
      busy_cnt <= cfg_busy;
    end else if (busy_cnt > 0 && !stuck) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (FlashDataWrite && FlashDataWaitReq) wr_age <= wr_age + 1;
    else                                    wr_age <= 0;
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic expect_ev(input logic er, input logic [17:0] a, input logic [31:0] d);
    ev_t ev;
    ev.er = er; ev.addr = a; ev.data = d; ev.stable = 1'b1;
    exp_q.push_back(ev);
  endtask

  task automatic drain(input string tag);
    ev_t e;
    while (rd_ptr < obs.size()) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check(tag, obs[rd_ptr], e);
      rd_ptr++;
    end
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic issue(input logic [17:0] a, input logic [5:0] l,
                       input logic u, input logic w, input logic e, output bit acked);
    @(negedge clk);
    FlashOpAddr = a; FlashOpLen = l; FlashOpUnlock = u; FlashOpWr = w; FlashOpEr = e;
    acked = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (FlashCmdAck) begin acked = 1'b1; break; end
    end
    FlashOpUnlock = 1'b0; FlashOpWr = 1'b0; FlashOpEr = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    @(negedge clk);
    for (int k = 0; k < max; k++) begin
      if (!FlashBusy) begin ok = 1'b1; break; end
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit acked, ok, seen;
    int cyc, w0, e0, n0;
    for (int k = 0; k < 128; k++) ram[k] = 16'h0;
    ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'h3333; ram[3] = 16'h4444;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctl", {FlashCmdAck, FlashBusy, FlashError, FlashDataWrite, FlashErase}, 0);
    check("rst_bus", {BufRdAddress, FlashDataAddr, FlashDataWrData, FlashEraseAddr}, 0);
    Reset = 1'b0;

    // Two-word write with a 2-cycle stall on each word
    cfg_stall = 2; cfg_busy = 2;
    expect_ev(1'b0, 18'h100, 32'h22221111);
    expect_ev(1'b0, 18'h101, 32'h44443333);
    issue(18'h100, 6'd2, 1'b1, 1'b1, 1'b0, acked);
    check("wr_ack", acked, 1);
    wait_done(200, cyc, ok);
    check("wr_done", ok, 1);
    check("wr_busy_long", cyc >= 13, 1);
    check("wr_err", FlashError, 0);
    drain("wr_evt");
    cfg_stall = 0;

    // Erase with 50-cycle flash busy
    cfg_busy = 50; e0 = er_cycles;
    expect_ev(1'b1, 18'h800, 32'h0);
    issue(18'h800, 6'd0, 1'b1, 1'b0, 1'b1, acked);
    check("er_ack", acked, 1);
    wait_done(200, cyc, ok);
    check("er_done", ok, 1);
    check("er_busy_long", cyc >= 50, 1);
    check("er_err", FlashError, 0);
    check("er_pulse", er_cycles - e0, 1);
    drain("er_evt");
    cfg_busy = 2;

    // Write without unlock is ignored
    w0 = wr_cycles; e0 = er_cycles; seen = 1'b0;
    issue(18'h100, 6'd1, 1'b0, 1'b1, 1'b0, acked);
    check("nolock_ack", acked, 0);
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (FlashBusy) seen = 1'b1; end
    check("nolock_busy", seen, 0);
    check("nolock_strobe", (wr_cycles - w0) + (er_cycles - e0), 0);

    // Wr and Er both set -> error, no strobes; then valid erase clears it
    w0 = wr_cycles; e0 = er_cycles;
    issue(18'h10, 6'd1, 1'b1, 1'b1, 1'b1, acked);
    check("both_ack", acked, 1);
    wait_done(20, cyc, ok);
    check("both_done", ok, 1);
    check("both_err", FlashError, 1);
    check("both_strobe", (wr_cycles - w0) + (er_cycles - e0), 0);
    cfg_busy = 5;
    expect_ev(1'b1, 18'h10, 32'h0);
    issue(18'h10, 6'd0, 1'b1, 1'b0, 1'b1, acked);
    check("clr_ack", acked, 1);
    wait_done(100, cyc, ok);
    check("clr_done", ok, 1);
    check("clr_err", FlashError, 0);
    drain("clr_evt");
    cfg_busy = 2;

    // Write crossing the end of flash
    w0 = wr_cycles;
    issue(18'h0FFFF, 6'd2, 1'b1, 1'b1, 1'b0, acked);
    check("ovr_ack", acked, 1);
    wait_done(20, cyc, ok);
    check("ovr_err", FlashError, 1);
    check("ovr_nowrite", wr_cycles - w0, 0);

    // Write ending exactly at the end of flash is legal
    expect_ev(1'b0, 18'h0FFFE, 32'h22221111);
    expect_ev(1'b0, 18'h0FFFF, 32'h44443333);
    issue(18'h0FFFE, 6'd2, 1'b1, 1'b1, 1'b0, acked);
    check("edge_ack", acked, 1);
    wait_done(200, cyc, ok);
    check("edge_done", ok, 1);
    check("edge_err", FlashError, 0);
    drain("edge_evt");

    // Erase past the end of flash
    e0 = er_cycles;
    issue(18'h10000, 6'd0, 1'b1, 1'b0, 1'b1, acked);
    wait_done(20, cyc, ok);
    check("er_ovr_err", FlashError, 1);
    check("er_ovr_noerase", er_cycles - e0, 0);

    // Zero-length write: ack, no access, error cleared
    w0 = wr_cycles;
    issue(18'h40, 6'd0, 1'b1, 1'b1, 1'b0, acked);
    check("len0_ack", acked, 1);
    wait_done(20, cyc, ok);
    check("len0_busy_cyc", cyc, 1);
    check("len0_err", FlashError, 0);
    check("len0_nowrite", wr_cycles - w0, 0);

    // Flash busy stuck after a write -> timeout abort
    expect_ev(1'b0, 18'h200, 32'h22221111);
    issue(18'h200, 6'd1, 1'b1, 1'b1, 1'b0, acked);
    stuck = 1'b1;
    check("tmo_ack", acked, 1);
    repeat (90) @(negedge clk);
    check("tmo_early", {FlashError, FlashBusy}, 2'b01);
    repeat (30) @(negedge clk);
    check("tmo_err", {FlashError, FlashBusy, FlashDataWrite}, 3'b100);
    stuck = 1'b0;
    drain("tmo_evt");
    repeat (5) @(negedge clk);

    // Reset during a stalled write
    force_stall = 1'b1; seen = 1'b0;
    issue(18'h300, 6'd1, 1'b1, 1'b1, 1'b0, acked);
    for (int k = 0; k < 10; k++) begin
      if (FlashDataWrite) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("stall_write_seen", seen, 1);
    Reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", {FlashCmdAck, FlashBusy, FlashError, FlashDataWrite, FlashErase}, 0);
    check("mid_rst_bus", {BufRdAddress, FlashDataAddr, FlashDataWrData, FlashEraseAddr}, 0);
    Reset = 1'b0; force_stall = 1'b0; seen = 1'b0; n0 = obs.size();
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (FlashBusy || FlashDataWrite) seen = 1'b1; end
    check("post_rst_idle", seen, 0);
    check("post_rst_noevt", obs.size() - n0, 0);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
